// File: rtl/cache_refill_engine_pkg.sv
// Shared cache refill types: FSM state, line/beat containers, way index and address-field widths.
// Latency, backpressure and flow control are not applicable: types and constants only.
package cache_refill_engine_pkg;

  localparam int unsigned S_OFFSET  = 5;
  localparam int unsigned S_INDEX   = 4;
  localparam int unsigned S_TAG     = 23;
  localparam int unsigned BEAT_W    = 64;
  localparam int unsigned NUM_BEATS = 4;
  localparam int unsigned LINE_W    = BEAT_W * NUM_BEATS;
  localparam int unsigned NUM_WAYS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_FILL,
    ST_COMMIT
  } state_e;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [1:0]        way_t;
  typedef logic [1:0]        beat_idx_t;

  function automatic logic [NUM_WAYS-1:0] way_onehot(input way_t w);
    return NUM_WAYS'(1) << w;
  endfunction

endpackage

// File: rtl/cache_refill_engine_line_beat_buffer.sv
// Four-beat line register file: one beat written per cycle, whole line read out continuously.
// Write lands on the next rising edge; there is no backpressure, the writer qualifies each beat with we.
module cache_refill_engine_line_beat_buffer
  import cache_refill_engine_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  beat_idx_t waddr,
  input  beat_t     wdata,
  output line_t     line
);

  beat_t beat_q [NUM_BEATS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_BEATS; i++) beat_q[i] <= '0;
    end else if (we) begin
      beat_q[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NUM_BEATS; g++) begin : g_line
    assign line[g*BEAT_W +: BEAT_W] = beat_q[g];
  end

endmodule

// File: rtl/cache_refill_engine.sv
// Miss refill engine: optional dirty-victim write-back, line fill burst, one-cycle commit into the victim way.
// Clean miss takes 6 cycles and dirty miss 10, request to IDLE; mem_resp=0 stalls the burst, and miss_req is ignored while busy.
module cache_refill_engine
  import cache_refill_engine_pkg::*;
#(
  parameter int unsigned s_offset  = S_OFFSET,
  parameter int unsigned s_index   = S_INDEX,
  parameter int unsigned s_tag     = S_TAG,
  parameter int unsigned beat_w    = BEAT_W,
  parameter int unsigned num_beats = NUM_BEATS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_req,
  input  logic [s_tag-1:0]     miss_tag,
  input  logic [s_index-1:0]   miss_index,
  input  logic [1:0]           victim_way,
  input  logic                 victim_dirty,
  input  logic [s_tag-1:0]     victim_tag,
  input  logic [LINE_W-1:0]    victim_line,
  output logic                 busy,
  output logic [NUM_WAYS-1:0]  fill_we,
  output logic [LINE_W-1:0]    fill_line,
  output logic [s_tag-1:0]     fill_tag,
  output logic [s_index-1:0]   fill_index,
  output logic                 done,
  output logic [31:0]          mem_addr,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [beat_w-1:0]    mem_wdata,
  input  logic [beat_w-1:0]    mem_rdata,
  input  logic                 mem_resp
);

  state_e              state_q, state_d;
  beat_idx_t           cnt_q, cnt_d;
  logic [s_tag-1:0]    tag_q;
  logic [s_tag-1:0]    vtag_q;
  logic [s_index-1:0]  idx_q;
  way_t                way_q;
  line_t               snap_q;
  logic                last_beat;
  logic                accept;

  assign accept    = (state_q == ST_IDLE) && miss_req;
  assign last_beat = (cnt_q == 2'(num_beats - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          cnt_d   = '0;
          state_d = victim_dirty ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        // Counter wraps to 0 on the last beat, so FILL starts at beat 0.
        if (mem_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (last_beat) state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (mem_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (last_beat) state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q  <= '0;
      vtag_q <= '0;
      idx_q  <= '0;
      way_q  <= '0;
      snap_q <= '0;
    end else if (accept) begin
      tag_q  <= miss_tag;
      vtag_q <= victim_tag;
      idx_q  <= miss_index;
      way_q  <= victim_way;
      snap_q <= victim_line;
    end
  end

  cache_refill_engine_line_beat_buffer u_fill_buf (
    .clk   (clk),
    .rst   (rst),
    .we    ((state_q == ST_FILL) && mem_resp),
    .waddr (cnt_q),
    .wdata (mem_rdata),
    .line  (fill_line)
  );

  // Memory-side outputs decode only from state and latched fields, never from miss_req.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      ST_WB: begin
        mem_addr  = {vtag_q, idx_q, {s_offset{1'b0}}};
        mem_wdata = snap_q[int'(cnt_q)*beat_w +: beat_w];
      end
      ST_FILL: mem_addr = {tag_q, idx_q, {s_offset{1'b0}}};
      default: ;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign mem_write  = (state_q == ST_WB);
  assign mem_read   = (state_q == ST_FILL);
  assign done       = (state_q == ST_COMMIT);
  assign fill_we    = (state_q == ST_COMMIT) ? way_onehot(way_q) : '0;
  assign fill_tag   = tag_q;
  assign fill_index = idx_q;

endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed bench for cache_refill_engine: clean, dirty, stalled, ignored-request, mid-burst reset and stray-response cases.
module tb_cache_refill_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req, victim_dirty, mem_resp;
  logic [22:0]  miss_tag, victim_tag;
  logic [3:0]   miss_index;
  logic [1:0]   victim_way;
  logic [255:0] victim_line;
  logic [63:0]  mem_rdata;
  logic         busy, done, mem_read, mem_write;
  logic [3:0]   fill_we;
  logic [255:0] fill_line;
  logic [22:0]  fill_tag;
  logic [3:0]   fill_index;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] a_beat [4];
  logic [63:0] b_beat [4];
  logic [63:0] d_beat [4];

  always #5 clk = ~clk;

  cache_refill_engine dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_tag(miss_tag), .miss_index(miss_index),
    .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .victim_line(victim_line), .busy(busy), .fill_we(fill_we), .fill_line(fill_line),
    .fill_tag(fill_tag), .fill_index(fill_index), .done(done), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    miss_req = 0; victim_dirty = 0; mem_resp = 0;
    miss_tag = '0; victim_tag = '0; miss_index = '0; victim_way = '0;
    victim_line = '0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #12;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_bad++; $display("FAIL reset_mem_rw got=%b%b exp=00", mem_read, mem_write); end
    n_cmp++; if (fill_we !== 4'b0000) begin n_bad++; $display("FAIL reset_fill_we got=%b exp=0000", fill_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_cmp++; if (mem_wdata !== 64'h0) begin n_bad++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    n_cmp++; if (fill_line !== 256'h0) begin n_bad++; $display("FAIL reset_fill_line got=%h exp=0", fill_line); end
    n_cmp++; if (fill_tag !== 23'h0 || fill_index !== 4'h0) begin n_bad++; $display("FAIL reset_fill_tag_idx got=%h/%h exp=0/0", fill_tag, fill_index); end
    @(posedge clk); #1;
    rst = 1;
    step();
  endtask

  task automatic test_stray_resp();
    mem_resp = 1;
    for (int c = 0; c < 3; c++) begin
      mem_rdata = 64'h1122_3344_5566_7788 + 64'(c);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || fill_we !== 4'b0) begin n_bad++; $display("FAIL stray_ctrl c=%0d busy=%b done=%b we=%b exp=0", c, busy, done, fill_we); end
      n_cmp++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL stray_mem c=%0d rw=%b%b addr=%h exp=0", c, mem_read, mem_write, mem_addr); end
      n_cmp++; if (fill_line !== 256'h0) begin n_bad++; $display("FAIL stray_fill_line c=%0d got=%h exp=0", c, fill_line); end
      step();
    end
    mem_resp = 0;
  endtask

  task automatic test_clean_miss();
    int dones = 0;
    logic exp_rd;
    miss_tag = 23'h1234; miss_index = 4'd2; victim_way = 2'd3; victim_dirty = 0;
    victim_tag = 23'h7777; victim_line = {4{64'hFFFF_0000_FFFF_0000}}; mem_resp = 1;
    for (int c = 0; c < 8; c++) begin
      miss_req = (c == 0);
      mem_rdata = 64'hBAD0;
      if (c >= 1 && c <= 4) mem_rdata = a_beat[c-1];
      exp_rd = (c >= 1 && c <= 4);
      @(negedge clk);
      n_cmp++; if (mem_read !== exp_rd || mem_write !== 1'b0) begin n_bad++; $display("FAIL clean_rw c=%0d got=%b%b exp=%b0", c, mem_read, mem_write, exp_rd); end
      n_cmp++; if (mem_addr !== (exp_rd ? 32'h0024_6840 : 32'h0)) begin n_bad++; $display("FAIL clean_addr c=%0d got=%h", c, mem_addr); end
      n_cmp++; if (busy !== (c >= 1 && c <= 5)) begin n_bad++; $display("FAIL clean_busy c=%0d got=%b", c, busy); end
      n_cmp++; if (fill_we !== ((c == 5) ? 4'b1000 : 4'b0000) || done !== (c == 5)) begin n_bad++; $display("FAIL clean_commit c=%0d we=%b done=%b", c, fill_we, done); end
      if (c == 5) begin
        n_cmp++; if (fill_line !== {a_beat[3], a_beat[2], a_beat[1], a_beat[0]}) begin n_bad++; $display("FAIL clean_fill_line got=%h", fill_line); end
        n_cmp++; if (fill_tag !== 23'h1234 || fill_index !== 4'd2) begin n_bad++; $display("FAIL clean_fill_tag_idx got=%h/%h exp=1234/2", fill_tag, fill_index); end
      end
      if (done) dones++;
      step();
    end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL clean_done_count got=%0d exp=1", dones); end
    idle_inputs();
  endtask

  task automatic test_dirty_miss();
    logic exp_wr, exp_rd;
    logic [31:0] exp_addr;
    logic [63:0] exp_wd;
    miss_tag = 23'h0ABC; miss_index = 4'd5; victim_way = 2'd0; victim_dirty = 1;
    victim_tag = 23'h0001; victim_line = {d_beat[3], d_beat[2], d_beat[1], d_beat[0]}; mem_resp = 1;
    for (int c = 0; c < 11; c++) begin
      miss_req = (c == 0);
      mem_rdata = 64'hBAD1;
      if (c >= 5 && c <= 8) mem_rdata = b_beat[c-5];
      exp_wr = (c >= 1 && c <= 4);
      exp_rd = (c >= 5 && c <= 8);
      exp_addr = exp_wr ? 32'h0000_02A0 : (exp_rd ? 32'h0015_78A0 : 32'h0);
      exp_wd = 64'h0;
      if (exp_wr) exp_wd = d_beat[c-1];
      @(negedge clk);
      n_cmp++; if (mem_write !== exp_wr || mem_read !== exp_rd) begin n_bad++; $display("FAIL dirty_rw c=%0d got=%b%b exp=%b%b", c, mem_write, mem_read, exp_wr, exp_rd); end
      n_cmp++; if (mem_addr !== exp_addr) begin n_bad++; $display("FAIL dirty_addr c=%0d got=%h exp=%h", c, mem_addr, exp_addr); end
      n_cmp++; if (mem_wdata !== exp_wd) begin n_bad++; $display("FAIL dirty_wdata c=%0d got=%h exp=%h", c, mem_wdata, exp_wd); end
      n_cmp++; if (fill_we !== ((c == 9) ? 4'b0001 : 4'b0000) || done !== (c == 9)) begin n_bad++; $display("FAIL dirty_commit c=%0d we=%b done=%b", c, fill_we, done); end
      if (c == 9) begin
        n_cmp++; if (fill_line !== {b_beat[3], b_beat[2], b_beat[1], b_beat[0]}) begin n_bad++; $display("FAIL dirty_fill_line got=%h", fill_line); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    int dones = 0;
    logic exp_wr, exp_rd;
    logic [31:0] exp_addr;
    logic [63:0] exp_wd;
    miss_tag = 23'h0ABC; miss_index = 4'd5; victim_way = 2'd0; victim_dirty = 1;
    victim_tag = 23'h0001; victim_line = {d_beat[3], d_beat[2], d_beat[1], d_beat[0]};
    for (int c = 0; c < 27; c++) begin
      miss_req = (c == 0);
      mem_resp = (c % 3 == 2);
      mem_rdata = 64'hDEAD_BEEF_0000_0000 | 64'(c);
      if (c >= 12 && c <= 23 && mem_resp) mem_rdata = a_beat[(c-12)/3];
      exp_wr = (c >= 1 && c <= 11);
      exp_rd = (c >= 12 && c <= 23);
      exp_addr = exp_wr ? 32'h0000_02A0 : (exp_rd ? 32'h0015_78A0 : 32'h0);
      exp_wd = 64'h0;
      if (exp_wr) exp_wd = d_beat[c/3];
      @(negedge clk);
      n_cmp++; if (mem_write !== exp_wr || mem_read !== exp_rd) begin n_bad++; $display("FAIL stall_rw c=%0d got=%b%b exp=%b%b", c, mem_write, mem_read, exp_wr, exp_rd); end
      n_cmp++; if (mem_addr !== exp_addr || mem_wdata !== exp_wd) begin n_bad++; $display("FAIL stall_addr_data c=%0d got=%h/%h exp=%h/%h", c, mem_addr, mem_wdata, exp_addr, exp_wd); end
      n_cmp++; if (fill_we !== ((c == 24) ? 4'b0001 : 4'b0000)) begin n_bad++; $display("FAIL stall_fill_we c=%0d got=%b", c, fill_we); end
      if (c == 24) begin
        n_cmp++; if (fill_line !== {a_beat[3], a_beat[2], a_beat[1], a_beat[0]}) begin n_bad++; $display("FAIL stall_fill_line got=%h", fill_line); end
      end
      if (done) dones++;
      step();
    end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL stall_done_count got=%0d exp=1", dones); end
    idle_inputs();
  endtask

  task automatic test_ignore_req();
    int dones = 0;
    logic exp_rd;
    logic [31:0] exp_addr;
    logic [3:0] exp_we;
    mem_resp = 1;
    for (int c = 0; c < 13; c++) begin
      miss_req = (c == 0 || c == 2 || c == 6);
      if (c == 0) begin miss_tag = 23'h1234; miss_index = 4'd2; victim_way = 2'd3; victim_dirty = 0; end
      if (c == 2) begin miss_tag = 23'h0FFF; miss_index = 4'd9; victim_way = 2'd0; victim_dirty = 1; end
      if (c == 6) begin miss_tag = 23'h0055; miss_index = 4'd7; victim_way = 2'd1; victim_dirty = 0; end
      mem_rdata = 64'hBAD2;
      if (c >= 1 && c <= 4) mem_rdata = b_beat[c-1];
      if (c >= 7 && c <= 10) mem_rdata = a_beat[c-7];
      exp_rd = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
      exp_addr = (c >= 1 && c <= 4) ? 32'h0024_6840 : ((c >= 7 && c <= 10) ? 32'h0000_AAE0 : 32'h0);
      exp_we = (c == 5) ? 4'b1000 : ((c == 11) ? 4'b0010 : 4'b0000);
      @(negedge clk);
      n_cmp++; if (mem_read !== exp_rd || mem_write !== 1'b0) begin n_bad++; $display("FAIL ignore_rw c=%0d got=%b%b exp=%b0", c, mem_read, mem_write, exp_rd); end
      n_cmp++; if (mem_addr !== exp_addr) begin n_bad++; $display("FAIL ignore_addr c=%0d got=%h exp=%h", c, mem_addr, exp_addr); end
      n_cmp++; if (fill_we !== exp_we) begin n_bad++; $display("FAIL ignore_fill_we c=%0d got=%b exp=%b", c, fill_we, exp_we); end
      if (c == 5) begin
        n_cmp++; if (fill_tag !== 23'h1234 || fill_index !== 4'd2) begin n_bad++; $display("FAIL ignore_tag_first got=%h/%h exp=1234/2", fill_tag, fill_index); end
      end
      if (c == 11) begin
        n_cmp++; if (fill_line !== {a_beat[3], a_beat[2], a_beat[1], a_beat[0]} || fill_tag !== 23'h0055) begin n_bad++; $display("FAIL ignore_second_line tag=%h line=%h", fill_tag, fill_line); end
      end
      if (done) dones++;
      step();
    end
    n_cmp++; if (dones != 2) begin n_bad++; $display("FAIL ignore_done_count got=%0d exp=2", dones); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_fill();
    miss_tag = 23'h1234; miss_index = 4'd2; victim_way = 2'd3; victim_dirty = 0; mem_resp = 1;
    for (int c = 0; c < 3; c++) begin
      miss_req = (c == 0);
      mem_rdata = 64'hBAD3;
      if (c >= 1) mem_rdata = b_beat[c-1];
      @(negedge clk);
      if (c == 2) begin
        n_cmp++; if (mem_read !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_read got=%b exp=1", mem_read); end
      end
      step();
    end
    miss_req = 0;
    rst = 0;
    #1;
    n_cmp++; if (mem_read !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_drop read=%b busy=%b exp=0/0", mem_read, busy); end
    n_cmp++; if (fill_line !== 256'h0) begin n_bad++; $display("FAIL rstmid_line_cleared got=%h", fill_line); end
    step();
    rst = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (fill_we !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_commit c=%0d we=%b busy=%b done=%b", c, fill_we, busy, done); end
      step();
    end
    miss_tag = 23'h0321; miss_index = 4'hF; victim_way = 2'd2;
    for (int c = 0; c < 7; c++) begin
      miss_req = (c == 0);
      mem_rdata = 64'hBAD4;
      if (c >= 1 && c <= 4) mem_rdata = a_beat[c-1];
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 32'h0006_43E0) begin n_bad++; $display("FAIL rstmid_new_req read=%b addr=%h exp=1/000643e0", mem_read, mem_addr); end
      end
      n_cmp++; if (fill_we !== ((c == 5) ? 4'b0100 : 4'b0000)) begin n_bad++; $display("FAIL rstmid_new_we c=%0d got=%b", c, fill_we); end
      if (c == 5) begin
        n_cmp++; if (fill_line !== {a_beat[3], a_beat[2], a_beat[1], a_beat[0]}) begin n_bad++; $display("FAIL rstmid_new_line got=%h", fill_line); end
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    a_beat[0] = 64'hA0A0_0000_1111_0000; a_beat[1] = 64'hA1A1_0000_2222_0001;
    a_beat[2] = 64'hA2A2_0000_3333_0002; a_beat[3] = 64'hA3A3_0000_4444_0003;
    b_beat[0] = 64'hB0B0_5555_0000_1000; b_beat[1] = 64'hB1B1_6666_0000_1001;
    b_beat[2] = 64'hB2B2_7777_0000_1002; b_beat[3] = 64'hB3B3_8888_0000_1003;
    d_beat[0] = 64'hD0D0_9999_ABCD_2000; d_beat[1] = 64'hD1D1_AAAA_ABCD_2001;
    d_beat[2] = 64'hD2D2_BBBB_ABCD_2002; d_beat[3] = 64'hD3D3_CCCC_ABCD_2003;
    rst = 0;
    test_reset();
    test_stray_resp();
    test_clean_miss();
    test_dirty_miss();
    test_stall();
    test_ignore_req();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
